// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op codes, FSM states and counter sizing shared by the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;
    typedef enum logic [2:0] {
        MULT  = 3'b000,
        MULTU = 3'b001,
        DIV   = 3'b010,
        DIVU  = 3'b011,
        MTHI  = 3'b100,
        MTLO  = 3'b101,
        MADD  = 3'b110,
        MADDU = 3'b111
    } op_t;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/hilo_muldiv_core.sv
// hilo_muldiv_core: one shift-add (multiply) or restoring-subtract (divide) step on magnitudes.
// Ports: is_div selects the step; acc is the 2*WIDTH working register ({partial, multiplier} or
// {remainder, quotient}); b is the multiplicand or divisor magnitude; acc_nx is the stepped value.
module hilo_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nx
);
    logic [WIDTH:0] sum, sh, diff;
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        sh     = acc[2*WIDTH-1:WIDTH-1];
        diff   = sh - {1'b0, b};
        // a borrow out of the trial subtract means the divisor did not fit: keep the shifted remainder
        acc_nx = is_div ? (diff[WIDTH] ? {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                        : {sum, acc[WIDTH-1:1]};
    end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO register pair.
// Ports: clk, reset (async active-low); op_valid/op_ready issue handshake with op, rs_val, rt_val;
// busy while iterating; done one-cycle result pulse; div_zero sticky divide-by-zero flag; hi, lo.
// Define MULDIV_MACC_EN to turn op codes 110/111 into MADD/MADDU; otherwise they are no-ops.
module hilo_muldiv_unit
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_nx;
    op_t op_i, op_r;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] b, ma, mb, quo, rem;
    logic accept, iter, sgn, sa, sb, is_div_i, is_div, neg_q, neg_r, zf;

    assign op_i     = op_t'(op);
    assign accept   = op_valid && op_ready;
`ifdef MULDIV_MACC_EN
    assign iter     = !op[2] || op[1];
`else
    assign iter     = !op[2];
`endif
    assign sgn      = op_i inside {MULT, DIV, MADD};
    assign sa       = sgn && rs_val[WIDTH-1];
    assign sb       = sgn && rt_val[WIDTH-1];
    assign ma       = sa ? -rs_val : rs_val;
    assign mb       = sb ? -rt_val : rt_val;
    assign is_div_i = !op[2] && op[1];
    assign is_div   = op_r inside {DIV, DIVU};
    assign quo      = acc[WIDTH-1:0];
    assign rem      = acc[2*WIDTH-1:WIDTH];

    hilo_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .is_div (is_div),
        .acc    (acc),
        .b      (b),
        .acc_nx (acc_nx)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE) ? ((accept && iter) ? CALC : IDLE)
                 : (state == CALC) ? ((cnt == CW'(WIDTH - 1)) ? FIX : CALC)
                 : IDLE;
    end

    always_comb begin
        busy     = state != IDLE;
        op_ready = !busy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r     <= MULT;
            cnt      <= '0;
            acc      <= '0;
            b        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zf       <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= state == FIX;
            if (state == CALC) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                if (iter) begin
                    // divide iterates on the dividend, multiply on the multiplier; b holds the other
                    op_r     <= op_i;
                    cnt      <= '0;
                    neg_q    <= sa ^ sb;
                    neg_r    <= sa;
                    zf       <= is_div_i && (rt_val == '0);
                    div_zero <= 1'b0;
                    acc      <= {{WIDTH{1'b0}}, is_div_i ? ma : mb};
                    b        <= is_div_i ? mb : ma;
                end else if (op_i == MTHI) hi <= rs_val;
                else if (op_i == MTLO) lo <= rs_val;
                else div_zero <= 1'b0;
            end
            if (state == FIX) begin
                if (is_div) begin
                    // a zero divisor leaves the dividend magnitude in the remainder, so only lo needs forcing
                    lo       <= zf ? '1 : (neg_q ? -quo : quo);
                    hi       <= neg_r ? -rem : rem;
                    div_zero <= zf;
                end else {hi, lo} <= (op_r[2] ? {hi, lo} : '0) + (neg_q ? -acc : acc);
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: randomized scoreboard bench for hilo_muldiv_unit at WIDTH=32.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0, reset = 1'b0, op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic op_ready, busy, done, div_zero;
    logic [W-1:0] hi, lo;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           acc;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] mhi = '0, mlo = '0;
    logic mdz = 1'b0;
    int nvec = 0, nerr = 0, bcnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset) bcnt = 0;
        else begin
            if (busy) bcnt++;
            if (done) begin
                if (sb.size() == 0) check("unexpected_done", done, 0);
                else begin
                    e = sb.pop_front();
                    check("hi", hi, e.hi);
                    check("lo", lo, e.lo);
                    check("div_zero", div_zero, e.dz);
                    check("latency", cyc - e.acc, W + 1);
                    check("busy_cycles", bcnt, W + 1);
                    check("ready_in_done", op_ready, 1);
                end
                bcnt = 0;
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] bb,
                         output int acc_cyc);
        int t = 0;
        exp_t e;
        logic it;
        longint x, y;
        int sa, sbv;
        acc_cyc = 0;
        @(negedge clk);
        while (!op_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!op_ready) begin
            check("ready_timeout", op_ready, 1);
            return;
        end
        op_valid = 1'b1;
        op = o;
        rs_val = a;
        rt_val = bb;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 3'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        acc_cyc = cyc;
        it = 1'b1;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        x = $signed(a);
        y = $signed(bb);
        case (o)
            MULT:  {e.hi, e.lo} = x * y;
            MULTU: {e.hi, e.lo} = {32'b0, a} * {32'b0, bb};
            DIV: begin
                if (bb == 0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else if (a == 32'h8000_0000 && bb == 32'hffff_ffff) begin
                    e.lo = a;
                    e.hi = '0;
                end else begin
                    sa = $signed(a);
                    sbv = $signed(bb);
                    e.lo = sa / sbv;
                    e.hi = sa % sbv;
                end
            end
            DIVU: begin
                if (bb == 0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / bb;
                    e.hi = a % bb;
                end
            end
            MTHI: begin
                it = 1'b0;
                mhi = a;
            end
            MTLO: begin
                it = 1'b0;
                mlo = a;
            end
            default: begin
`ifdef MULDIV_MACC_EN
                {e.hi, e.lo} = {mhi, mlo} + ((o == MADD) ? x * y : {32'b0, a} * {32'b0, bb});
`else
                it = 1'b0;
                mdz = 1'b0;
`endif
            end
        endcase
        if (it) begin
            e.acc = acc_cyc;
            sb.push_back(e);
            mhi = e.hi;
            mlo = e.lo;
            mdz = e.dz;
            check("busy_after_accept", busy, 1);
            check("dz_clear_on_accept", div_zero, 0);
        end else begin
            check("hi_imm", hi, mhi);
            check("lo_imm", lo, mlo);
            check("dz_imm", div_zero, mdz);
            check("no_busy", busy, 0);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int a0, a1, a2;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_ready", op_ready, 1);
        reset = 1'b1;

        issue(MULT, 32'd5, 32'd7, a0);
        drain();
        issue(MULT, 32'hffff_ffff, 32'hffff_fffe, a0);
        issue(MULTU, 32'hffff_ffff, 32'hffff_fffe, a0);
        issue(DIV, 32'hffff_fff9, 32'd2, a0);
        issue(DIV, 32'h8000_0000, 32'hffff_ffff, a0);
        issue(DIVU, 32'd7, 32'd0, a0);
        issue(MULT, 32'd3, 32'd4, a0);
        issue(DIV, 32'h8000_0000, 32'd0, a0);
        issue(MTHI, 32'h1234_5678, 32'd0, a0);
        issue(MTLO, 32'h0000_000a, 32'd0, a0);
        issue(MTHI, 32'h0000_0000, 32'd0, a0);
        issue(MADD, 32'd5, 32'd7, a0);
        issue(MADDU, 32'hffff_ffff, 32'hffff_ffff, a0);
        issue(MULT, 32'd9, 32'hffff_fffd, a1);
        issue(MULTU, 32'd11, 32'd13, a2);
        check("back_to_back", a2 - a1, W + 2);
        drain();

        repeat (200) issue(3'($urandom), pick(), pick(), a0);
        drain();

        issue(DIVU, $urandom, $urandom | 32'd1, a0);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", op_ready, 1);
        sb.delete();
        mhi = '0;
        mlo = '0;
        mdz = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2 * W) @(negedge clk);
        issue(DIVU, 32'd100, 32'd7, a0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
